// File: rtl/ext_pipe.sv
// ext_pipe: pipelined immediate / load-data extension unit.
//   Modes: 0 ZERO, 1 SIGN, 2 HIGH (imm in the top bits), 3 BOFF (sign-extend, then << 2),
//          4 LB, 5 LBU, 6 LH, 7 LHU (byte/half lane taken from i_word by i_byte_off).
//   The result is registered through LATENCY stages (1..3). Outputs come from the last stage.
//   Stall holds every stage. Flush clears every stage and wins over stall and i_in_valid.
//   Reset is asynchronous and active-high, and clears every stage immediately.
//
// Optional feature macro: EXT_LOAD_MODES_EN
//   defined   : modes 4-7 extract a byte/half from i_word, and o_out_err flags a
//               halfword load with i_byte_off[0] = 1.
//   undefined : modes 4-7 behave as ZERO, o_out_err is tied 0, i_word/i_byte_off unused.
//
// Ports
//   i_clk        clock, rising edge
//   i_reset      asynchronous reset, active-high
//   i_in_valid   request valid this cycle
//   i_op[2:0]    extension mode
//   i_imm        immediate field (IMM_W bits)
//   i_word       aligned memory word for load modes (DATA_W bits)
//   i_byte_off   address[1:0] for load modes
//   i_stall      hold all stages; the request presented this cycle is not taken
//   i_flush      invalidate all stages
//   o_out_valid  o_out_data / o_out_err valid
//   o_out_data   extended result (0 when not valid)
//   o_out_err    misaligned halfword load (0 when not valid)

module ext_pipe #(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_in_valid,
  input  logic [2:0]        i_op,
  input  logic [IMM_W-1:0]  i_imm,
  input  logic [DATA_W-1:0] i_word,
  input  logic [1:0]        i_byte_off,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic              o_out_valid,
  output logic [DATA_W-1:0] o_out_data,
  output logic              o_out_err
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (LATENCY < 1 || LATENCY > 3) begin : g_bad_latency
    $error("ext_pipe: LATENCY must be 1..3, got %0d", LATENCY);
  end

  if (IMM_W < 2 || IMM_W > DATA_W / 2) begin : g_bad_imm_w
    $error("ext_pipe: IMM_W must satisfy 2 <= IMM_W <= DATA_W/2, got %0d", IMM_W);
  end

`ifdef EXT_LOAD_MODES_EN
  if (DATA_W != 32) begin : g_bad_data_w
    $error("ext_pipe: DATA_W must be 32 when load modes are enabled, got %0d", DATA_W);
  end
`endif

  // ---------------------------------------------------------------------------
  // Immediate extensions
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_imm_zext;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_high;
  logic [DATA_W-1:0] w_imm_boff;

  assign w_imm_zext = {{(DATA_W-IMM_W){1'b0}}, i_imm};
  assign w_imm_sext = {{(DATA_W-IMM_W){i_imm[IMM_W-1]}}, i_imm};
  assign w_imm_high = {i_imm, {(DATA_W-IMM_W){1'b0}}};
  // Same-width shift: the two top bits of the sign-extended value fall off.
  assign w_imm_boff = w_imm_sext << 2;

  // ---------------------------------------------------------------------------
  // Load-data lane extraction
  // ---------------------------------------------------------------------------
`ifdef EXT_LOAD_MODES_EN
  logic [7:0]        w_lane_byte;
  logic [15:0]       w_lane_half;
  logic [DATA_W-1:0] w_lb;
  logic [DATA_W-1:0] w_lbu;
  logic [DATA_W-1:0] w_lh;
  logic [DATA_W-1:0] w_lhu;
  logic              w_half_misaligned;

  always_comb begin
    w_lane_byte = i_word[7:0];
    case (i_byte_off)
      2'd0:    w_lane_byte = i_word[7:0];
      2'd1:    w_lane_byte = i_word[15:8];
      2'd2:    w_lane_byte = i_word[23:16];
      default: w_lane_byte = i_word[31:24];
    endcase
  end

  // Only byte_off[1] picks the half; byte_off[0] is reported as an error
  // rather than being used to realign the data.
  assign w_lane_half       = i_byte_off[1] ? i_word[31:16] : i_word[15:0];
  assign w_half_misaligned = i_byte_off[0];

  assign w_lb  = {{(DATA_W-8){w_lane_byte[7]}}, w_lane_byte};
  assign w_lbu = {{(DATA_W-8){1'b0}}, w_lane_byte};
  assign w_lh  = {{(DATA_W-16){w_lane_half[15]}}, w_lane_half};
  assign w_lhu = {{(DATA_W-16){1'b0}}, w_lane_half};
`else
  // Load inputs are not consumed in this build; fold them into one sink net.
  logic w_unused_load_inputs;
  assign w_unused_load_inputs = ^{i_word, i_byte_off};
`endif

  // ---------------------------------------------------------------------------
  // Mode select (combinational result feeding stage 0)
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_res_data;
  logic              w_res_err;

  always_comb begin
    w_res_data = w_imm_zext;
    w_res_err  = 1'b0;
    case (i_op)
      3'd0: w_res_data = w_imm_zext;
      3'd1: w_res_data = w_imm_sext;
      3'd2: w_res_data = w_imm_high;
      3'd3: w_res_data = w_imm_boff;
`ifdef EXT_LOAD_MODES_EN
      3'd4: w_res_data = w_lb;
      3'd5: w_res_data = w_lbu;
      3'd6: begin
        w_res_data = w_lh;
        w_res_err  = w_half_misaligned;
      end
      3'd7: begin
        w_res_data = w_lhu;
        w_res_err  = w_half_misaligned;
      end
`endif
      default: w_res_data = w_imm_zext;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline stages
  // ---------------------------------------------------------------------------
  // Bubbles and flushes load zero data/err, so the last stage is all-zero
  // whenever it is invalid and the outputs need no extra gating.
  logic              r_v    [LATENCY];
  logic [DATA_W-1:0] r_data [LATENCY];
  logic              r_err  [LATENCY];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_v[i]    <= 1'b0;
        r_data[i] <= '0;
        r_err[i]  <= 1'b0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_v[i]    <= 1'b0;
        r_data[i] <= '0;
        r_err[i]  <= 1'b0;
      end
    end else if (!i_stall) begin
      r_v[0]    <= i_in_valid;
      r_data[0] <= i_in_valid ? w_res_data : '0;
      r_err[0]  <= i_in_valid ? w_res_err  : 1'b0;
      for (int i = 1; i < LATENCY; i++) begin
        r_v[i]    <= r_v[i-1];
        r_data[i] <= r_data[i-1];
        r_err[i]  <= r_err[i-1];
      end
    end
  end

  assign o_out_valid = r_v[LATENCY-1];
  assign o_out_data  = r_data[LATENCY-1];
  assign o_out_err   = r_err[LATENCY-1];

endmodule

// File: tb/tb_ext_pipe.sv
// Testbench for ext_pipe: two instances (LATENCY=1 and LATENCY=3) share one input stream.
// A queue-based model predicts each instance's outputs and is compared every cycle;
// directed vectors additionally pin hand-computed literal results.
module tb_ext_pipe;

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        e;
  } ent_t;

`ifdef EXT_LOAD_MODES_EN
  localparam bit LOAD_EN = 1'b1;
`else
  localparam bit LOAD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [15:0] imm;
  logic [31:0] word;
  logic [1:0]  byte_off;
  logic        stall;
  logic        flush;

  logic        v1, v3, e1, e3;
  logic [31:0] d1, d3;

  int errors = 0;
  int checks = 0;

  ext_pipe #(.IMM_W(16), .DATA_W(32), .LATENCY(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .i_op(op), .i_imm(imm),
    .i_word(word), .i_byte_off(byte_off), .i_stall(stall), .i_flush(flush),
    .o_out_valid(v1), .o_out_data(d1), .o_out_err(e1)
  );

  ext_pipe #(.IMM_W(16), .DATA_W(32), .LATENCY(3)) u3 (
    .i_clk(clk), .i_reset(rst), .i_in_valid(in_valid), .i_op(op), .i_imm(imm),
    .i_word(word), .i_byte_off(byte_off), .i_stall(stall), .i_flush(flush),
    .o_out_valid(v3), .o_out_data(d3), .o_out_err(e3)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic longint sx(longint x, int w);
    if (x >= (longint'(1) << (w - 1))) return x - (longint'(1) << w);
    return x;
  endfunction

  // Returns {err, data} for one request, straight from the mode definitions.
  function automatic logic [32:0] model_ext(logic [2:0] op_i, logic [15:0] imm_i,
                                            logic [31:0] word_i, logic [1:0] off_i);
    longint      iv, v, b, h;
    int          hsh;
    logic        err;
    logic [63:0] vb;
    iv  = longint'(imm_i);
    b   = longint'((word_i >> (8 * int'(off_i))) & 32'hFF);
    hsh = (int'(off_i) / 2) * 16;
    h   = longint'((word_i >> hsh) & 32'hFFFF);
    err = 1'b0;
    case (op_i)
      3'd0: v = iv;
      3'd1: v = sx(iv, 16);
      3'd2: v = iv * 65536;
      3'd3: v = sx(iv, 16) * 4;
      3'd4: v = LOAD_EN ? sx(b, 8) : iv;
      3'd5: v = LOAD_EN ? b : iv;
      3'd6: v = LOAD_EN ? sx(h, 16) : iv;
      default: v = LOAD_EN ? h : iv;
    endcase
    if (LOAD_EN && op_i >= 3'd6 && (int'(off_i) % 2 == 1)) err = 1'b1;
    vb = v;
    return {err, vb[31:0]};
  endfunction

  // History of pipeline advances, newest first; the output is the entry LATENCY-1 back.
  ent_t q1[$];
  ent_t q3[$];
  ent_t m_new;
  logic [32:0] m_res;

  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      q1.delete();
      q3.delete();
    end else if (!stall) begin
      if (in_valid) begin
        m_res   = model_ext(op, imm, word, byte_off);
        m_new.v = 1'b1;
        m_new.d = m_res[31:0];
        m_new.e = m_res[32];
      end else begin
        m_new.v = 1'b0;
        m_new.d = 32'h0;
        m_new.e = 1'b0;
      end
      q1.push_front(m_new);
      q3.push_front(m_new);
      while (q1.size() > 1) void'(q1.pop_back());
      while (q3.size() > 3) void'(q3.pop_back());
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the rising edge.
  ent_t x1, x3;
  always @(negedge clk) begin
    x1 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    x3 = '{v: 1'b0, d: 32'h0, e: 1'b0};
    if (q1.size() >= 1) x1 = q1[0];
    if (q3.size() >= 3) x3 = q3[2];
    chk("model_l1", {d1[29:0], v1, e1}, {x1.d[29:0], x1.v, x1.e});
    chk("model_l1_hi", {30'h0, d1[31:30]}, {30'h0, x1.d[31:30]});
    chk("model_l3", {d3[29:0], v3, e3}, {x3.d[29:0], x3.v, x3.e});
    chk("model_l3_hi", {30'h0, d3[31:30]}, {30'h0, x3.d[31:30]});
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [2:0] o, input logic [15:0] i,
                        input logic [31:0] w, input logic [1:0] off);
    in_valid = v; op = o; imm = i; word = w; byte_off = off;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    tick();
    chk("reset_l1", {31'h0, v1} | d1 | {31'h0, e1}, 32'h0);
    chk("reset_l3", {31'h0, v3} | d3 | {31'h0, e3}, 32'h0);
    rst = 1'b0;
    tick();

    // Immediate modes on the LATENCY=1 instance.
    set_in(1'b1, 3'd1, 16'h8000, 32'h0, 2'd0); tick();
    chk("sign_valid", {31'h0, v1}, 32'h1);
    chk("sign_8000", d1, 32'hFFFF8000);
    set_in(1'b1, 3'd0, 16'h8000, 32'h0, 2'd0); tick();
    chk("zero_8000", d1, 32'h00008000);
    set_in(1'b1, 3'd2, 16'h1234, 32'h0, 2'd0); tick();
    chk("high_1234", d1, 32'h12340000);
    set_in(1'b1, 3'd3, 16'hFFFF, 32'h0, 2'd0); tick();
    chk("boff_ffff", d1, 32'hFFFFFFFC);
    set_in(1'b1, 3'd3, 16'h0004, 32'h0, 2'd0); tick();
    chk("boff_0004", d1, 32'h00000010);

`ifdef EXT_LOAD_MODES_EN
    set_in(1'b1, 3'd4, 16'h0, 32'h80F1_7F02, 2'd1); tick();
    chk("lb_off1", d1, 32'h0000007F);
    set_in(1'b1, 3'd4, 16'h0, 32'h80F1_7F02, 2'd2); tick();
    chk("lb_off2", d1, 32'hFFFFFFF1);
    set_in(1'b1, 3'd6, 16'h0, 32'h80F1_7F02, 2'd2); tick();
    chk("lh_off2", d1, 32'hFFFF80F1);
    chk("lh_off2_err", {31'h0, e1}, 32'h0);
    set_in(1'b1, 3'd7, 16'h0, 32'h80F1_7F02, 2'd3); tick();
    chk("lhu_off3", d1, 32'h000080F1);
    chk("lhu_off3_err", {31'h0, e1}, 32'h1);
`else
    set_in(1'b1, 3'd5, 16'hABCD, 32'h80F1_7F02, 2'd3); tick();
    chk("op5_as_zero", d1, 32'h0000ABCD);
    chk("op5_err", {31'h0, e1}, 32'h0);
    set_in(1'b1, 3'd7, 16'h1357, 32'hFFFF_FFFF, 2'd1); tick();
    chk("op7_as_zero", d1, 32'h00001357);
    chk("op7_err", {31'h0, e1}, 32'h0);
`endif

    set_in(1'b0, 3'd1, 16'hFFFF, 32'hFFFF_FFFF, 2'd0); tick();
    chk("bubble_l1", {31'h0, v1} | d1 | {31'h0, e1}, 32'h0);
    tick(); tick(); tick();
    chk("drained_l3", {31'h0, v3}, 32'h0);

    // Stall for two cycles while A sits in stage 1 of the LATENCY=3 instance.
    set_in(1'b1, 3'd1, 16'h0001, 32'h0, 2'd0); tick();        // A accepted
    set_in(1'b1, 3'd0, 16'h0002, 32'h0, 2'd0); tick();        // B accepted
    set_in(1'b1, 3'd2, 16'h0003, 32'h0, 2'd0); stall = 1'b1;  // C held by requester
    tick();
    chk("stall1_l3_valid", {31'h0, v3}, 32'h0);
    tick();
    chk("stall2_l3_valid", {31'h0, v3}, 32'h0);
    stall = 1'b0; tick();                                      // C accepted
    chk("out_A", {d3[30:0], v3}, {31'h1, 1'b1});
    set_in(1'b0, 3'd0, 16'h0, 32'h0, 2'd0); tick();
    chk("out_B", {d3[30:0], v3}, {31'h2, 1'b1});
    tick();
    chk("out_C", d3, 32'h00030000);
    chk("out_C_valid", {31'h0, v3}, 32'h1);
    tick();
    chk("after_C", {31'h0, v3}, 32'h0);

    // Full pipe, then flush + stall + in_valid together.
    set_in(1'b1, 3'd0, 16'h0011, 32'h0, 2'd0); tick();
    set_in(1'b1, 3'd0, 16'h0022, 32'h0, 2'd0); tick();
    set_in(1'b1, 3'd0, 16'h0033, 32'h0, 2'd0); tick();
    chk("full_l3", {d3[30:0], v3}, {31'h11, 1'b1});
    set_in(1'b1, 3'd1, 16'h7777, 32'h0, 2'd0); flush = 1'b1; stall = 1'b1;
    tick();
    chk("flush_l3", {31'h0, v3} | d3, 32'h0);
    chk("flush_l1", {31'h0, v1} | d1, 32'h0);
    flush = 1'b0; stall = 1'b0;
    set_in(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    tick(); tick();
    chk("flush_not_captured_a", {31'h0, v3}, 32'h0);
    tick();
    chk("flush_not_captured_b", {31'h0, v3}, 32'h0);

    // Asynchronous reset between edges while outputs are valid.
    set_in(1'b1, 3'd7, 16'h8000, 32'h80F1_7F02, 2'd3); tick();
    chk("pre_reset_valid", {31'h0, v1}, 32'h1);
    set_in(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_l1", {31'h0, v1} | d1 | {31'h0, e1}, 32'h0);
    chk("async_reset_l3", {31'h0, v3} | d3 | {31'h0, e3}, 32'h0);
    tick();
    rst = 1'b0;
    set_in(1'b1, 3'd1, 16'h00FF, 32'h0, 2'd0); tick();
    chk("post_reset", d1, 32'h000000FF);
    set_in(1'b0, 3'd0, 16'h0, 32'h0, 2'd0);
    tick(); tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
